// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one single-port SRAM; grants in IDLE, then ISSUE -> (RDWAIT) -> RESP.
// Latency: write Ack in 2nd cycle after grant edge, read Ack + Rdata in 3rd cycle; all outputs registered.
// Backpressure: requesters hold ReqN until AckN; requests seen outside IDLE wait for IDLE. Macro SRAM_ARB_RR_EN selects round-robin ties.
module sram_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata0,
  output logic [DATA_W-1:0] Rdata1,
  output logic              SramCS,
  output logic              SramWE,
  output logic              SramRD,
  output logic [ADDR_W-1:0] SramAddr,
  output logic [DATA_W-1:0] SramDataIn,
  input  logic [DATA_W-1:0] SramQ,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;      // 0 = port 0 owns the transaction, 1 = port 1
  logic                we_q, we_d;        // latched write flag, survives past ISSUE
  logic [ADDR_W-1:0]   addr_q, addr_d;    // doubles as SramAddr, holds outside ISSUE
  logic [DATA_W-1:0]   wdata_q, wdata_d;  // doubles as SramDataIn, holds outside ISSUE
  logic                cs_q, cs_d;
  logic                swe_q, swe_d;
  logic                srd_q, srd_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                grant;
`ifdef SRAM_ARB_RR_EN
  logic                last_q, last_d;    // port granted most recently
`endif

  // Winner selection among current requests
  always_comb begin
`ifdef SRAM_ARB_RR_EN
    if (Req0 && Req1) grant = ~last_q;
    else              grant = ~Req0;
`else
    grant = ~Req0;
`endif
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cs_d     = 1'b0;
    swe_d    = 1'b0;
    srd_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          win_d   = grant;
          we_d    = grant ? We1 : We0;
          addr_d  = grant ? Addr1 : Addr0;
          wdata_d = grant ? Wdata1 : Wdata0;
          cs_d    = 1'b1;
          swe_d   = we_d;
          srd_d   = ~we_d;
          state_d = ISSUE;
`ifdef SRAM_ARB_RR_EN
          last_d  = grant;
`endif
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
          ack0_d  = ~win_q;
          ack1_d  = win_q;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        // SRAM data is valid during this cycle; capture it alongside the Ack
        if (win_q) rdata1_d = SramQ;
        else       rdata0_d = SramQ;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b0;
      swe_q    <= 1'b0;
      srd_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      swe_q    <= swe_d;
      srd_q    <= srd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
`ifdef SRAM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign Ack0       = ack0_q;
  assign Ack1       = ack1_q;
  assign Rdata0     = rdata0_q;
  assign Rdata1     = rdata1_q;
  assign SramCS     = cs_q;
  assign SramWE     = swe_q;
  assign SramRD     = srd_q;
  assign SramAddr   = addr_q;
  assign SramDataIn = wdata_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model with a behavioural SRAM.
// Each round predicts the winner, SRAM strobes, Ack timing and read data from a reference memory.
// Requesters hold Req until Ack; random phase varies drops, back-to-back and late arrivals.
module tb_sram_arbiter;
  localparam int DW = 4;
  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          Ack0, Ack1, SramCS, SramWE, SramRD, Busy;
  logic [DW-1:0] Rdata0, Rdata1, SramDataIn;
  logic [AW-1:0] SramAddr;
  logic [DW-1:0] SramQ = '0;
  logic [DW-1:0] sram_mem [4] = '{default: '0};

  logic [DW-1:0] ref_mem [4] = '{default: '0};
  logic [DW-1:0] exp_rd  [2];
  int n_tests = 0;
  int n_fail  = 0;
`ifdef SRAM_ARB_RR_EN
  int last_grant = 1;
`endif

  always #5 Clk = ~Clk;

  sram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(req[0]), .Req1(req[1]), .We0(we[0]), .We1(we[1]),
    .Addr0(addr[0]), .Addr1(addr[1]), .Wdata0(wdata[0]), .Wdata1(wdata[1]),
    .Ack0(Ack0), .Ack1(Ack1), .Rdata0(Rdata0), .Rdata1(Rdata1),
    .SramCS(SramCS), .SramWE(SramWE), .SramRD(SramRD),
    .SramAddr(SramAddr), .SramDataIn(SramDataIn), .SramQ(SramQ), .Busy(Busy)
  );

  // Behavioural SRAM: write on CS&WE, read data appears the cycle after CS&RD
  always @(posedge Clk) begin
    if (SramCS && SramWE) sram_mem[SramAddr] <= SramDataIn;
    if (SramCS && SramRD) SramQ <= sram_mem[SramAddr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},  {Ack1, Ack0}, 0);
    check({tag, "_sram"}, {SramCS, SramWE, SramRD}, 0);
    check({tag, "_addr"}, SramAddr, 0);
    check({tag, "_din"},  SramDataIn, 0);
    check({tag, "_rd0"},  Rdata0, 0);
    check({tag, "_rd1"},  Rdata1, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  task automatic new_req(input int i);
    req[i]   = 1'b1;
    we[i]    = 1'($urandom_range(0, 1));
    addr[i]  = AW'($urandom_range(0, 3));
    wdata[i] = DW'($urandom_range(0, 15));
  endtask

  task automatic set_req(input int i, input bit w, input int a, input int d);
    req[i] = 1'b1; we[i] = w; addr[i] = AW'(a); wdata[i] = DW'(d);
  endtask

  function automatic int pick();
    if (req[0] && req[1]) begin
`ifdef SRAM_ARB_RR_EN
      return (last_grant == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return req[0] ? 0 : 1;
  endfunction

  // One arbitration round, entered and left at a negedge of an IDLE cycle.
  // mode 0: random follow-up requests; 1: requester drops after Ack; 2: requester keeps requesting.
  task automatic do_round(input int mode, input bit drop_w);
    int w;
    bit ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!req[0] && !req[1]) begin
      @(posedge Clk); @(negedge Clk);
      check("idle_busy", Busy, 0);
      check("idle_cs", SramCS, 0);
      if (mode == 0) for (int i = 0; i < 2; i++) if ($urandom_range(0, 1) == 1) new_req(i);
      return;
    end
    w  = pick();
    ew = we[w]; ea = addr[w]; ed = wdata[w];
`ifdef SRAM_ARB_RR_EN
    last_grant = w;
`endif
    @(posedge Clk); @(negedge Clk);
    check("iss_busy", Busy, 1);
    check("iss_strobes", {SramCS, SramWE, SramRD}, {1'b1, ew, ~ew});
    check("iss_addr", SramAddr, ea);
    check("iss_din", SramDataIn, ed);
    check("iss_ack", {Ack1, Ack0}, 0);
    if (ew) ref_mem[ea] = ed;
    if (drop_w) begin
      new_req(w);
      req[w] = 1'b0;
    end
    if (mode == 0 && !req[1-w] && $urandom_range(0, 2) == 0) new_req(1 - w);
    if (!ew) begin
      @(posedge Clk); @(negedge Clk);
      check("rdw_strobes", {SramCS, SramWE, SramRD}, 0);
      check("rdw_addr", SramAddr, ea);
      check("rdw_ack", {Ack1, Ack0}, 0);
      check("rdw_busy", Busy, 1);
      exp_rd[w] = ref_mem[ea];
    end
    @(posedge Clk); @(negedge Clk);
    check("resp_ack", {Ack1, Ack0}, (w == 1) ? 2 : 1);
    check("resp_strobes", {SramCS, SramWE, SramRD}, 0);
    check("resp_busy", Busy, 1);
    check("resp_rd0", Rdata0, exp_rd[0]);
    check("resp_rd1", Rdata1, exp_rd[1]);
    if (mode == 0) begin
      if ($urandom_range(0, 3) != 0) new_req(w);
      else req[w] = 1'b0;
    end else if (mode == 1) begin
      req[w] = 1'b0;
    end
    @(posedge Clk); @(negedge Clk);
    check("post_busy", Busy, 0);
    check("post_ack", {Ack1, Ack0}, 0);
    check("post_cs", SramCS, 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; exp_rd[i] = '0;
    end
    repeat (2) @(negedge Clk);
    check_zero("rst");
    Rst_n = 1'b1;

    // Directed write then read-back on port 0
    set_req(0, 1'b1, 0, 15);
    do_round(1, 1'b0);
    set_req(0, 1'b0, 0, 0);
    do_round(1, 1'b0);
    check("rdback_rd0", Rdata0, 15);
    check("rdback_rd1", Rdata1, 0);

    // Both ports held reading 01 and 10
    set_req(0, 1'b0, 1, 0);
    set_req(1, 1'b0, 2, 0);
    repeat (4) do_round(2, 1'b0);
    req[0] = 1'b0;
    do_round(2, 1'b0);
    req[1] = 1'b0;
    do_round(1, 1'b0);

    // Port 1 write dropped right after grant: completes once, nothing follows
    set_req(1, 1'b1, 3, 10);
    do_round(1, 1'b1);
    do_round(1, 1'b0);
    do_round(1, 1'b0);

    // Randomized traffic
    repeat (150) do_round(0, $urandom_range(0, 3) == 0);

    // Reset asserted during a port 1 read wait
    for (int i = 0; i < 2; i++) req[i] = 1'b0;
    do_round(1, 1'b0);
    do_round(1, 1'b0);
    set_req(1, 1'b0, 1, 0);
    @(posedge Clk); @(negedge Clk);
    check("mid_iss_rd", SramRD, 1);
    req[1] = 1'b0;
    @(posedge Clk); @(negedge Clk);
    check("mid_rdw_cs", SramCS, 0);
    #1 Rst_n = 1'b0;
    #1 check_zero("midrst");
    exp_rd[0] = '0; exp_rd[1] = '0;
`ifdef SRAM_ARB_RR_EN
    last_grant = 1;
`endif
    @(posedge Clk); @(negedge Clk);
    check_zero("midrst_hold");
    Rst_n = 1'b1;

    // First tie after reset goes to port 0, then the model decides the next
    set_req(0, 1'b0, 3, 0);
    set_req(1, 1'b0, 0, 0);
    do_round(2, 1'b0);
    do_round(1, 1'b0);
    do_round(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
